qam64_symbol_mapper: RTL and testbench

Upstream stage of the 64-QAM modulator chain. It accepts a byte stream with a valid/ready handshake and repacks it into 6-bit symbols, four symbols per three bytes. Each symbol is mapped to a pair of 4-bit signed I/Q constellation levels in {-7,-5,…,+5,+7}. The I/Q pair is presented, with its own valid/ready handshake, to the upsampling/filter stage that consumes 4-bit symbol data.

---
 rtl/qam64_pkg.sv | 42 ++++
 rtl/qam64_gearbox.sv | 83 ++++++++
 rtl/qam64_symbol_mapper.sv | 78 +++++++
 tb/tb_qam64_symbol_mapper.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/qam64_pkg.sv
// Shared constants, level type and the per-axis constellation map for the 64-QAM mapper.
// QAM64_GRAY_MAP_EN selects the Gray per-axis map; otherwise natural binary (2*v - 7).
package qam64_pkg;

  localparam int SYM_BITS = 6;
  localparam int LEVEL_W  = 4;
  localparam int BUF_W    = 16;
  localparam int CNT_W    = 5;

  typedef logic signed [LEVEL_W-1:0] qam_level_t;

  function automatic qam_level_t map_axis(input logic [2:0] v);
    qam_level_t lvl;
`ifdef QAM64_GRAY_MAP_EN
    case (v)
      3'b000:  lvl = 4'sb1001;  // -7
      3'b001:  lvl = 4'sb1011;  // -5
      3'b011:  lvl = 4'sb1101;  // -3
      3'b010:  lvl = 4'sb1111;  // -1
      3'b110:  lvl = 4'sb0001;  // +1
      3'b111:  lvl = 4'sb0011;  // +3
      3'b101:  lvl = 4'sb0101;  // +5
      3'b100:  lvl = 4'sb0111;  // +7
      default: lvl = 4'sb1001;
    endcase
`else
    case (v)
      3'b000:  lvl = 4'sb1001;
      3'b001:  lvl = 4'sb1011;
      3'b010:  lvl = 4'sb1101;
      3'b011:  lvl = 4'sb1111;
      3'b100:  lvl = 4'sb0001;
      3'b101:  lvl = 4'sb0011;
      3'b110:  lvl = 4'sb0101;
      3'b111:  lvl = 4'sb0111;
      default: lvl = 4'sb1001;
    endcase
`endif
    return lvl;
  endfunction

endpackage

// File: rtl/qam64_gearbox.sv
// 8-to-6 bit gearbox: 16-bit MSB-first buffer, fill count, frame flush and zero-pad symbol.
// Valid bits are left-aligned; everything below the fill count is kept zero so padding is free.
module qam64_gearbox
  import qam64_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [SYM_BITS-1:0] raw_sym_o,
  output logic                raw_last_o,
  output logic                raw_avail_o,
  input  logic                take_i
);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             full_s, pad_s, accept_s, pop_s;

  // Handshake decode, pop/pad selection and next buffer state
  always_comb begin
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    full_s      = (cnt_q >= 5'd6);
    pad_s       = flush_q && !full_s && (cnt_q != 5'd0);
    raw_avail_o = full_s || pad_s;
    raw_sym_o   = buf_q[BUF_W-1 -: SYM_BITS];
    raw_last_o  = flush_q && (pad_s || (cnt_q == 5'd6));
    in_ready    = !flush_q && (cnt_q <= 5'd8);
    accept_s    = in_valid && in_ready;
    pop_s       = raw_avail_o && take_i;

    if (pop_s) begin
      if (pad_s) begin
        buf_d = 16'h0000;
        cnt_d = 5'd0;
      end else begin
        buf_d = buf_q << SYM_BITS;
        cnt_d = cnt_q - 5'd6;
      end
    end else begin
      buf_d = buf_q;
      cnt_d = cnt_q;
    end

    // New byte lands directly behind whatever survives this cycle's pop.
    if (accept_s) begin
      buf_d = buf_d | ({in_data, 8'h00} >> cnt_d);
      cnt_d = cnt_d + 5'd8;
    end else begin
      buf_d = buf_d;
      cnt_d = cnt_d;
    end

    if (accept_s && in_last) begin
      flush_d = 1'b1;
    end else if (pop_s && raw_last_o) begin
      flush_d = 1'b0;
    end else if (flush_q && (cnt_q == 5'd0)) begin
      flush_d = 1'b0;
    end else begin
      flush_d = flush_q;
    end
  end

  // Buffer, fill count and flush state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= 16'h0000;
      cnt_q   <= 5'd0;
      flush_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: rtl/qam64_symbol_mapper.sv
// 64-QAM symbol mapper top: gearbox, I/Q level mapping and the registered output stage.
// Map selection via QAM64_GRAY_MAP_EN (see qam64_pkg); handshake is identical in both builds.
module qam64_symbol_mapper
  import qam64_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [LEVEL_W-1:0] sym_i,
  output logic [LEVEL_W-1:0] sym_q,
  output logic               sym_valid,
  output logic               sym_last,
  input  logic               sym_ready
);

  logic [SYM_BITS-1:0] raw_sym_s;
  logic                raw_last_s, raw_avail_s, take_s, pop_s;
  logic [LEVEL_W-1:0]  sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic                valid_q, valid_d, last_q, last_d;

  assign take_s = !valid_q || sym_ready;
  assign pop_s  = raw_avail_s && take_s;

  qam64_gearbox u_gearbox (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .raw_sym_o   (raw_sym_s),
    .raw_last_o  (raw_last_s),
    .raw_avail_o (raw_avail_s),
    .take_i      (take_s)
  );

  // Output stage next state: load on pop, drop valid on consume, otherwise hold
  always_comb begin
    sym_i_d = sym_i_q;
    sym_q_d = sym_q_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (pop_s) begin
      sym_i_d = map_axis(raw_sym_s[5:3]);
      sym_q_d = map_axis(raw_sym_s[2:0]);
      valid_d = 1'b1;
      last_d  = raw_last_s;
    end else if (sym_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_i_q <= 4'h0;
      sym_q_q <= 4'h0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sym_i_q <= sym_i_d;
      sym_q_q <= sym_q_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign sym_i     = sym_i_q;
  assign sym_q     = sym_q_q;
  assign sym_valid = valid_q;
  assign sym_last  = last_q;

endmodule

// File: tb/tb_qam64_symbol_mapper.sv
// Directed self-checking bench for qam64_symbol_mapper; expectations follow QAM64_GRAY_MAP_EN.
module tb_qam64_symbol_mapper;

  localparam logic [3:0] M7 = 4'b1001, M5 = 4'b1011, M3 = 4'b1101, M1 = 4'b1111;
  localparam logic [3:0] P1 = 4'b0001, P3 = 4'b0011, P5 = 4'b0101, P7 = 4'b0111;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [3:0] sym_i, sym_q;
  logic       sym_valid, sym_last, sym_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] got_q[$];

  qam64_symbol_mapper dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid),
    .sym_last(sym_last), .sym_ready(sym_ready)
  );

  always #5 clk = ~clk;

  // Record every symbol that will transfer on the coming rising edge
  always @(negedge clk) begin
    if (!rst && sym_valid && sym_ready) got_q.push_back({sym_last, sym_i, sym_q});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    in_data = d; in_valid = 1'b1; in_last = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 100) begin
        n_err++;
        $display("FAIL send_byte_timeout: byte %h never accepted", d);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_syms(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; sym_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (sym_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", sym_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if ({sym_valid, sym_last} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {sym_valid, sym_last}); end
    n_cmp++; if ({sym_i, sym_q} !== 8'h00) begin n_err++; $display("FAIL rst_iq: got %h want 00", {sym_i, sym_q}); end
  endtask

  task automatic test_zeros();
    sym_ready = 1'b1;
    got_q.delete();
    send_byte(8'h00, 1'b0);
    n_cmp++; if (sym_valid !== 1'b0) begin n_err++; $display("FAIL lat_early: got %b want 0", sym_valid); end
    @(posedge clk); #1;
    n_cmp++; if (sym_valid !== 1'b1) begin n_err++; $display("FAIL lat_rise: got %b want 1", sym_valid); end
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_syms(4);
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL zeros_count: got %0d want 4", got_q.size()); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (k >= got_q.size()) begin n_err++; $display("FAIL zeros_sym%0d: missing", k); end
      else if (got_q[k] !== {1'b0, M7, M7}) begin n_err++; $display("FAIL zeros_sym%0d: got %h want %h", k, got_q[k], {1'b0, M7, M7}); end
    end
  endtask

  task automatic test_pattern();
    logic [8:0] exp [4];
`ifdef QAM64_GRAY_MAP_EN
    exp[0] = {1'b0, M7, M5}; exp[1] = {1'b0, M1, M3}; exp[2] = {1'b0, P7, P5}; exp[3] = {1'b0, P1, P3};
`else
    exp[0] = {1'b0, M7, M5}; exp[1] = {1'b0, M3, M1}; exp[2] = {1'b0, P1, P3}; exp[3] = {1'b0, P5, P7};
`endif
    sym_ready = 1'b1;
    got_q.delete();
    send_byte(8'h05, 1'b0);
    send_byte(8'h39, 1'b0);
    send_byte(8'h77, 1'b0);
    wait_syms(4);
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL pattern_count: got %0d want 4", got_q.size()); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (k >= got_q.size()) begin n_err++; $display("FAIL pattern_sym%0d: missing", k); end
      else if (got_q[k] !== exp[k]) begin n_err++; $display("FAIL pattern_sym%0d: got %h want %h", k, got_q[k], exp[k]); end
    end
  endtask

  task automatic test_pad();
    logic [8:0] exp [2];
`ifdef QAM64_GRAY_MAP_EN
    exp[0] = {1'b0, P5, M5}; exp[1] = {1'b1, M1, M7};
`else
    exp[0] = {1'b0, P3, M5}; exp[1] = {1'b1, M3, M7};
`endif
    sym_ready = 1'b1;
    got_q.delete();
    send_byte(8'hA5, 1'b1);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pad_ready0: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pad_ready1: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pad_ready2: got %b want 1", in_ready); end
    wait_syms(2);
    n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL pad_count: got %0d want 2", got_q.size()); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (k >= got_q.size()) begin n_err++; $display("FAIL pad_sym%0d: missing", k); end
      else if (got_q[k] !== exp[k]) begin n_err++; $display("FAIL pad_sym%0d: got %h want %h", k, got_q[k], exp[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] lv;
`ifdef QAM64_GRAY_MAP_EN
    lv = P3;
`else
    lv = P7;
`endif
    sym_ready = 1'b0;
    got_q.delete();
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_fall: got %b want 0", in_ready); end
    in_data = 8'hFF; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({sym_valid, in_ready, sym_i, sym_q} !== {1'b1, 1'b0, lv, lv}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%b rdy=%b iq=%h want v=1 rdy=0 iq=%h", c, sym_valid, in_ready, {sym_i, sym_q}, {lv, lv});
      end
    end
    sym_ready = 1'b1; in_valid = 1'b0;
    for (int b = 0; b < 4; b++) send_byte(8'hFF, 1'b0);
    wait_syms(8);
    n_cmp++; if (got_q.size() != 8) begin n_err++; $display("FAIL bp_count: got %0d want 8", got_q.size()); end
    for (int k = 0; k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== {1'b0, lv, lv}) begin n_err++; $display("FAIL bp_sym%0d: got %h want %h", k, got_q[k], {1'b0, lv, lv}); end
    end
  endtask

  task automatic test_reset_mid();
    sym_ready = 1'b1;
    send_byte(8'h12, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if (sym_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", sym_valid); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sym_valid, sym_last, sym_i, sym_q, in_ready} !== {2'b00, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL mid_rst_outputs: got %b want 00000000001", {sym_valid, sym_last, sym_i, sym_q, in_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    for (int b = 0; b < 3; b++) send_byte(8'h00, 1'b0);
    wait_syms(4);
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL mid_count: got %0d want 4", got_q.size()); end
    for (int k = 0; k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== {1'b0, M7, M7}) begin n_err++; $display("FAIL mid_sym%0d: got %h want %h", k, got_q[k], {1'b0, M7, M7}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp [6];
`ifdef QAM64_GRAY_MAP_EN
    exp[0] = {1'b0, M7, M5}; exp[1] = {1'b1, M1, M7};
    exp[2] = {1'b0, M5, P1}; exp[3] = {1'b0, M1, P3}; exp[4] = {1'b0, M3, P7}; exp[5] = {1'b1, M7, P5};
`else
    exp[0] = {1'b0, M7, M5}; exp[1] = {1'b1, M3, M7};
    exp[2] = {1'b0, M5, P5}; exp[3] = {1'b0, M3, P7}; exp[4] = {1'b0, M1, P1}; exp[5] = {1'b1, M7, P3};
`endif
    sym_ready = 1'b1;
    got_q.delete();
    send_byte(8'h05, 1'b1);
    send_byte(8'h39, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h05, 1'b1);
    wait_syms(6);
    n_cmp++; if (got_q.size() != 6) begin n_err++; $display("FAIL b2b_count: got %0d want 6", got_q.size()); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (k >= got_q.size()) begin n_err++; $display("FAIL b2b_sym%0d: missing", k); end
      else if (got_q[k] !== exp[k]) begin n_err++; $display("FAIL b2b_sym%0d: got %h want %h", k, got_q[k], exp[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_pattern();
    test_pad();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
